// File: rtl/text_console_writer.sv
// Byte-stream console front end that keeps a cursor and writes glyphs into the 80x30 word-packed text VRAM.
// Build option CONSOLE_AUTOSCROLL_EN: scroll the screen up on overflow past the last row; otherwise wrap to row 0 and blank it.
module text_console_writer #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CHAR_VALID,
   input  logic [7:0]  CHAR_DATA,
   output logic        CHAR_READY,
   output logic        BUSY,
   output logic [9:0]  MEM_ADDR,
   output logic        MEM_WRITE,
   output logic [3:0]  MEM_BYTE_EN,
   output logic [31:0] MEM_WRITEDATA,
   output logic        MEM_READ,
   input  logic [31:0] MEM_READDATA,
   output logic [6:0]  CURSOR_COL,
   output logic [4:0]  CURSOR_ROW
);

   localparam int WORDS     = COLS * ROWS / 4;
   localparam int ROW_WORDS = COLS / 4;
   localparam logic [6:0] LAST_COL  = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
   localparam logic [9:0] LAST_WORD = 10'(WORDS - 1);
`ifdef CONSOLE_AUTOSCROLL_EN
   localparam logic [9:0] LAST_MOVE = 10'(WORDS - ROW_WORDS - 1);
`endif

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PUT       = 3'd1,
`ifdef CONSOLE_AUTOSCROLL_EN
      SCROLL_RD = 3'd2,
      SCROLL_WR = 3'd3,
`endif
      CLEAR     = 3'd4
   } state_t;

   state_t      state;
   logic [6:0]  col;
   logic [4:0]  row;
   logic [9:0]  clear_end;
   logic [31:0] wdata_q;
`ifdef CONSOLE_AUTOSCROLL_EN
   logic [9:0]  scroll_idx;
`endif

   logic       accept;
   logic       printable;
   logic       take_newline;
   logic [9:0] cursor_word;

   // Newline can come from an explicit LF or from a glyph landing in the last column.
   always_comb begin
      accept       = CHAR_VALID && (state == IDLE);
      printable    = ((CHAR_DATA >= 8'h20) && (CHAR_DATA <= 8'h7E)) ||
                     ((CHAR_DATA >= 8'hA0) && (CHAR_DATA <= 8'hFE));
      take_newline = (accept && (CHAR_DATA == 8'h0A)) ||
                     ((state == PUT) && (col == LAST_COL));
      cursor_word  = 10'(row) * 10'(ROW_WORDS) + 10'(col[6:2]);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         col         <= 7'd0;
         row         <= 5'd0;
         clear_end   <= 10'd0;
         wdata_q     <= 32'h0;
         MEM_ADDR    <= 10'd0;
         MEM_WRITE   <= 1'b0;
         MEM_READ    <= 1'b0;
         MEM_BYTE_EN <= 4'h0;
`ifdef CONSOLE_AUTOSCROLL_EN
         scroll_idx  <= 10'd0;
`endif
      end else begin
         MEM_WRITE   <= 1'b0;
         MEM_READ    <= 1'b0;
         MEM_ADDR    <= 10'd0;
         MEM_BYTE_EN <= 4'h0;
         wdata_q     <= 32'h0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (printable) begin
                     state       <= PUT;
                     MEM_WRITE   <= 1'b1;
                     MEM_ADDR    <= cursor_word;
                     MEM_BYTE_EN <= 4'b0001 << col[1:0];
                     wdata_q     <= {4{CHAR_DATA}};
                  end else begin
                     case (CHAR_DATA)
                        8'h0D: col <= 7'd0;
                        8'h0A: col <= 7'd0;
                        8'h08: if (col != 7'd0) col <= col - 7'd1;
                        8'h0C: begin
                           col         <= 7'd0;
                           row         <= 5'd0;
                           state       <= CLEAR;
                           MEM_WRITE   <= 1'b1;
                           MEM_ADDR    <= 10'd0;
                           MEM_BYTE_EN <= 4'hF;
                           clear_end   <= LAST_WORD;
                        end
                        default: ;
                     endcase
                  end
               end
            end
            PUT: begin
               state <= IDLE;
               if (col == LAST_COL) col <= 7'd0;
               else                 col <= col + 7'd1;
            end
`ifdef CONSOLE_AUTOSCROLL_EN
            SCROLL_RD: begin
               state       <= SCROLL_WR;
               MEM_WRITE   <= 1'b1;
               MEM_ADDR    <= scroll_idx;
               MEM_BYTE_EN <= 4'hF;
            end
            // Each word moves up one row; the final row is then blanked by CLEAR.
            SCROLL_WR: begin
               if (scroll_idx == LAST_MOVE) begin
                  state       <= CLEAR;
                  MEM_WRITE   <= 1'b1;
                  MEM_ADDR    <= LAST_MOVE + 10'd1;
                  MEM_BYTE_EN <= 4'hF;
                  clear_end   <= LAST_WORD;
               end else begin
                  scroll_idx <= scroll_idx + 10'd1;
                  state      <= SCROLL_RD;
                  MEM_READ   <= 1'b1;
                  MEM_ADDR   <= scroll_idx + 10'(ROW_WORDS) + 10'd1;
               end
            end
`endif
            CLEAR: begin
               if (MEM_ADDR == clear_end) begin
                  state <= IDLE;
               end else begin
                  MEM_WRITE   <= 1'b1;
                  MEM_ADDR    <= MEM_ADDR + 10'd1;
                  MEM_BYTE_EN <= 4'hF;
               end
            end
            default: state <= IDLE;
         endcase

         // Newline overrides whatever the state case chose for the next cycle.
         if (take_newline) begin
            if (row == LAST_ROW) begin
`ifdef CONSOLE_AUTOSCROLL_EN
               state      <= SCROLL_RD;
               scroll_idx <= 10'd0;
               MEM_READ   <= 1'b1;
               MEM_ADDR   <= 10'(ROW_WORDS);
`else
               row         <= 5'd0;
               state       <= CLEAR;
               MEM_WRITE   <= 1'b1;
               MEM_ADDR    <= 10'd0;
               MEM_BYTE_EN <= 4'hF;
               clear_end   <= 10'(ROW_WORDS - 1);
`endif
            end else begin
               row   <= row + 5'd1;
               state <= IDLE;
            end
         end
      end
   end

   assign CHAR_READY = (state == IDLE);
   assign BUSY       = (state != IDLE);
   assign CURSOR_COL = col;
   assign CURSOR_ROW = row;

`ifdef CONSOLE_AUTOSCROLL_EN
   assign MEM_WRITEDATA = (state == SCROLL_WR) ? MEM_READDATA : wdata_q;
`else
   logic unused_readdata;
   assign unused_readdata = ^MEM_READDATA;
   assign MEM_WRITEDATA   = wdata_q;
`endif

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed scenarios and random bytes checked against a character-grid model of the screen.
module tb_text_console_writer;

   localparam int COLS      = 80;
   localparam int ROWS      = 30;
   localparam int ROW_WORDS = COLS / 4;
   localparam int WORDS     = COLS * ROWS / 4;
`ifdef CONSOLE_AUTOSCROLL_EN
   localparam int OVERFLOW_CYCLES = (ROWS - 1) * ROW_WORDS * 2 + ROW_WORDS;
   localparam int OVERFLOW_READS  = (ROWS - 1) * ROW_WORDS;
   localparam int RESET_DELAY     = 300;
`else
   localparam int OVERFLOW_CYCLES = ROW_WORDS;
   localparam int OVERFLOW_READS  = 0;
   localparam int RESET_DELAY     = 10;
`endif

   logic        CLK;
   logic        RESET;
   logic        CHAR_VALID;
   logic [7:0]  CHAR_DATA;
   logic        CHAR_READY;
   logic        BUSY;
   logic [9:0]  MEM_ADDR;
   logic        MEM_WRITE;
   logic [3:0]  MEM_BYTE_EN;
   logic [31:0] MEM_WRITEDATA;
   logic        MEM_READ;
   logic [31:0] MEM_READDATA = '0;
   logic [6:0]  CURSOR_COL;
   logic [4:0]  CURSOR_ROW;

   text_console_writer dut (
      .CLK(CLK), .RESET(RESET), .CHAR_VALID(CHAR_VALID), .CHAR_DATA(CHAR_DATA),
      .CHAR_READY(CHAR_READY), .BUSY(BUSY), .MEM_ADDR(MEM_ADDR), .MEM_WRITE(MEM_WRITE),
      .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READ(MEM_READ),
      .MEM_READDATA(MEM_READDATA), .CURSOR_COL(CURSOR_COL), .CURSOR_ROW(CURSOR_ROW)
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // VRAM stand-in plus per-window activity counters
   logic [31:0] vram [WORDS];
   logic [9:0]  wlog_addr [$];
   logic [3:0]  wlog_be   [$];
   logic [31:0] wlog_data [$];
   int wr_count, rd_count, busy_count, ready_low;
   int protocol_err = 0;

   always @(posedge CLK) begin
      if (MEM_READ === 1'b1 && MEM_ADDR < 10'(WORDS)) MEM_READDATA <= vram[MEM_ADDR];
      if (MEM_WRITE === 1'b1 && MEM_ADDR < 10'(WORDS))
         for (int n = 0; n < 4; n++)
            if (MEM_BYTE_EN[n]) vram[MEM_ADDR][n*8 +: 8] <= MEM_WRITEDATA[n*8 +: 8];
      if (RESET === 1'b0) begin
         if (MEM_WRITE === 1'b1) begin
            wr_count++;
            wlog_addr.push_back(MEM_ADDR);
            wlog_be.push_back(MEM_BYTE_EN);
            wlog_data.push_back(MEM_WRITEDATA);
         end
         if (MEM_READ === 1'b1) rd_count++;
         if (BUSY === 1'b1) busy_count++;
         if (CHAR_READY !== 1'b1) ready_low++;
         if (MEM_READ === 1'b1 && MEM_WRITE === 1'b1) protocol_err++;
         if (BUSY === 1'b0 && (MEM_READ !== 1'b0 || MEM_WRITE !== 1'b0)) protocol_err++;
         if (MEM_ADDR > 10'd599) protocol_err++;
      end
   end

   // Reference model: the screen as a character grid plus a cursor
   logic [7:0] screen [ROWS][COLS];
   int mcol, mrow;

   function automatic int modelNewline();
      mcol = 0;
      if (mrow < ROWS - 1) begin
         mrow++;
         return 0;
      end
`ifdef CONSOLE_AUTOSCROLL_EN
      for (int r = 0; r < ROWS - 1; r++)
         for (int c = 0; c < COLS; c++) screen[r][c] = screen[r+1][c];
      for (int c = 0; c < COLS; c++) screen[ROWS-1][c] = 8'h00;
`else
      mrow = 0;
      for (int c = 0; c < COLS; c++) screen[0][c] = 8'h00;
`endif
      return OVERFLOW_CYCLES;
   endfunction

   // Returns the number of cycles the block should stay busy for this byte.
   function automatic int modelByte(input logic [7:0] b);
      if ((b >= 8'h20 && b <= 8'h7E) || (b >= 8'hA0 && b <= 8'hFE)) begin
         screen[mrow][mcol] = b;
         if (mcol == COLS - 1) return 1 + modelNewline();
         mcol++;
         return 1;
      end
      case (b)
         8'h0D: mcol = 0;
         8'h0A: return modelNewline();
         8'h08: if (mcol > 0) mcol--;
         8'h0C: begin
            for (int r = 0; r < ROWS; r++)
               for (int c = 0; c < COLS; c++) screen[r][c] = 8'h00;
            mcol = 0;
            mrow = 0;
            return WORDS;
         end
         default: ;
      endcase
      return 0;
   endfunction

   function automatic logic [31:0] modelWord(input int i);
      int r, c;
      r = i / ROW_WORDS;
      c = (i % ROW_WORDS) * 4;
      return {screen[r][c+3], screen[r][c+2], screen[r][c+1], screen[r][c]};
   endfunction

   function automatic int vramMismatches();
      int m = 0;
      for (int i = 0; i < WORDS; i++) if (vram[i] !== modelWord(i)) m++;
      return m;
   endfunction

   task automatic prefillVram();
      for (int i = 0; i < WORDS; i++) vram[i] = 32'(i);
      for (int i = 0; i < WORDS; i++)
         for (int n = 0; n < 4; n++)
            screen[i / ROW_WORDS][(i % ROW_WORDS) * 4 + n] = vram[i][n*8 +: 8];
   endtask

   task automatic clearLog();
      wr_count   = 0;
      rd_count   = 0;
      busy_count = 0;
      ready_low  = 0;
      wlog_addr.delete();
      wlog_be.delete();
      wlog_data.delete();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic timeoutFail(input string tag);
      total++;
      bad++;
      $error("[TB] FAIL %s observed=timeout expected=handshake", tag);
   endtask

   // Offer one byte, wait for it to be taken, then wait for the block to go idle again.
   task automatic applyStimulus(input logic [7:0] b);
      int guard;
      @(negedge CLK);
      CHAR_VALID = 1'b1;
      CHAR_DATA  = b;
      guard = 0;
      while (CHAR_READY !== 1'b1 && guard < 5000) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 5000) timeoutFail("ready_wait");
      @(posedge CLK);
      #1;
      CHAR_VALID = 1'b0;
      guard = 0;
      while (BUSY !== 1'b0 && guard < 5000) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 5000) timeoutFail("busy_wait");
   endtask

   task automatic sendModelled(input logic [7:0] b);
      void'(modelByte(b));
      applyStimulus(b);
   endtask

   initial begin
      int exp_busy;
      int bad_seq;
      logic [7:0] b;
      logic [6:0] exp_col [4];
      logic [4:0] exp_row [4];
      logic [7:0] ctrl    [4];

      CHAR_VALID = 1'b0;
      CHAR_DATA  = 8'h00;
      RESET      = 1'b1;
      prefillVram();
      mcol = 0;
      mrow = 0;
      clearLog();
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);

      $display("[TB] reset values");
      checkOutput("rst_ready", 32'(CHAR_READY), 32'd1);
      checkOutput("rst_busy", 32'(BUSY), 32'd0);
      checkOutput("rst_write", 32'(MEM_WRITE), 32'd0);
      checkOutput("rst_read", 32'(MEM_READ), 32'd0);
      checkOutput("rst_addr", 32'(MEM_ADDR), 32'd0);
      checkOutput("rst_be", 32'(MEM_BYTE_EN), 32'd0);
      checkOutput("rst_wdata", MEM_WRITEDATA, 32'd0);
      checkOutput("rst_col", 32'(CURSOR_COL), 32'd0);
      checkOutput("rst_row", 32'(CURSOR_ROW), 32'd0);

      $display("[TB] single glyph");
      clearLog();
      exp_busy = modelByte(8'h41);
      applyStimulus(8'h41);
      checkOutput("a_wr_count", 32'(wr_count), 32'd1);
      checkOutput("a_addr", 32'(wlog_addr[0]), 32'd0);
      checkOutput("a_be", 32'(wlog_be[0]), 32'h1);
      checkOutput("a_data", wlog_data[0], 32'h41414141);
      checkOutput("a_col", 32'(CURSOR_COL), 32'd1);
      checkOutput("a_row", 32'(CURSOR_ROW), 32'd0);
      checkOutput("a_ready_low", 32'(ready_low), 32'd1);
      checkOutput("a_busy", 32'(busy_count), 32'(exp_busy));

      $display("[TB] byte lanes within one word");
      sendModelled(8'h0D);
      clearLog();
      sendModelled(8'h48);
      sendModelled(8'h49);
      sendModelled(8'h21);
      sendModelled(8'hC1);
      checkOutput("lane_wr_count", 32'(wr_count), 32'd4);
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("lane%0d_be", k), 32'(wlog_be[k]), 32'(4'b0001 << k));
         checkOutput($sformatf("lane%0d_addr", k), 32'(wlog_addr[k]), 32'd0);
      end
      checkOutput("lane_data3", wlog_data[3], 32'hC1C1C1C1);
      checkOutput("lane_col", 32'(CURSOR_COL), 32'd4);
      clearLog();
      sendModelled(8'h5A);
      checkOutput("fifth_addr", 32'(wlog_addr[0]), 32'd1);
      checkOutput("fifth_be", 32'(wlog_be[0]), 32'h1);

      $display("[TB] control codes from (5,3)");
      while (mrow < 3) sendModelled(8'h0A);
      sendModelled(8'h0D);
      for (int k = 0; k < 5; k++) sendModelled(8'h61);
      ctrl[0] = 8'h08; exp_col[0] = 7'd4; exp_row[0] = 5'd3;
      ctrl[1] = 8'h0D; exp_col[1] = 7'd0; exp_row[1] = 5'd3;
      ctrl[2] = 8'h0A; exp_col[2] = 7'd0; exp_row[2] = 5'd4;
      ctrl[3] = 8'h07; exp_col[3] = 7'd0; exp_row[3] = 5'd4;
      clearLog();
      for (int k = 0; k < 4; k++) begin
         sendModelled(ctrl[k]);
         checkOutput($sformatf("ctl%0d_col", k), 32'(CURSOR_COL), 32'(exp_col[k]));
         checkOutput($sformatf("ctl%0d_row", k), 32'(CURSOR_ROW), 32'(exp_row[k]));
      end
      checkOutput("ctl_no_write", 32'(wr_count), 32'd0);

      $display("[TB] random bytes");
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: b = ($urandom_range(0, 1) == 0) ? 8'(8'h20 + $urandom_range(0, 94))
                                                                 : 8'(8'hA0 + $urandom_range(0, 94));
            6: b = 8'h0D;
            7: b = 8'h0A;
            8: b = 8'h08;
            default: b = 8'($urandom_range(0, 255));
         endcase
         clearLog();
         exp_busy = modelByte(b);
         applyStimulus(b);
         checkOutput($sformatf("rnd%0d_col_b%02h", k, b), 32'(CURSOR_COL), 32'(mcol));
         checkOutput($sformatf("rnd%0d_row_b%02h", k, b), 32'(CURSOR_ROW), 32'(mrow));
         checkOutput($sformatf("rnd%0d_busy_b%02h", k, b), 32'(busy_count), 32'(exp_busy));
      end
      checkOutput("rnd_vram", 32'(vramMismatches()), 32'd0);

      $display("[TB] overflow past last row");
      while (mrow < ROWS - 1) sendModelled(8'h0A);
      sendModelled(8'h0D);
      for (int k = 0; k < COLS - 1; k++) sendModelled(8'h62);
      checkOutput("ovf_pre_col", 32'(CURSOR_COL), 32'd79);
      checkOutput("ovf_pre_row", 32'(CURSOR_ROW), 32'd29);
      prefillVram();
      clearLog();
      exp_busy = modelByte(8'h58);
      applyStimulus(8'h58);
      checkOutput("ovf_put_addr", 32'(wlog_addr[0]), 32'd599);
      checkOutput("ovf_put_be", 32'(wlog_be[0]), 32'h8);
      checkOutput("ovf_put_data", wlog_data[0], 32'h58585858);
      checkOutput("ovf_busy", 32'(busy_count), 32'(exp_busy));
      checkOutput("ovf_reads", 32'(rd_count), 32'(OVERFLOW_READS));
      checkOutput("ovf_writes", 32'(wr_count), 32'(1 + OVERFLOW_CYCLES - OVERFLOW_READS));
      checkOutput("ovf_col", 32'(CURSOR_COL), 32'd0);
      checkOutput("ovf_row", 32'(CURSOR_ROW), 32'(mrow));
`ifdef CONSOLE_AUTOSCROLL_EN
      checkOutput("ovf_word0", vram[0], 32'd20);
      checkOutput("ovf_word580", vram[580], 32'd0);
`else
      checkOutput("ovf_word0", vram[0], 32'd0);
      checkOutput("ovf_word20", vram[20], 32'd20);
`endif
      checkOutput("ovf_vram", 32'(vramMismatches()), 32'd0);

      $display("[TB] form feed");
      clearLog();
      exp_busy = modelByte(8'h0C);
      applyStimulus(8'h0C);
      checkOutput("ff_writes", 32'(wr_count), 32'd600);
      checkOutput("ff_busy", 32'(busy_count), 32'(exp_busy));
      checkOutput("ff_col", 32'(CURSOR_COL), 32'd0);
      checkOutput("ff_row", 32'(CURSOR_ROW), 32'd0);
      bad_seq = 0;
      foreach (wlog_addr[k])
         if (wlog_addr[k] !== 10'(k) || wlog_data[k] !== 32'h0 || wlog_be[k] !== 4'hF) bad_seq++;
      checkOutput("ff_sequence", 32'(bad_seq), 32'd0);
      checkOutput("ff_vram", 32'(vramMismatches()), 32'd0);

      $display("[TB] reset during overflow");
      while (mrow < ROWS - 1) sendModelled(8'h0A);
      @(negedge CLK);
      CHAR_VALID = 1'b1;
      CHAR_DATA  = 8'h0A;
      @(posedge CLK);
      #1 CHAR_VALID = 1'b0;
      repeat (RESET_DELAY) @(negedge CLK);
      checkOutput("mid_busy", 32'(BUSY), 32'd1);
      RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      checkOutput("mid_ready", 32'(CHAR_READY), 32'd1);
      checkOutput("mid_idle", 32'(BUSY), 32'd0);
      checkOutput("mid_write", 32'(MEM_WRITE), 32'd0);
      checkOutput("mid_read", 32'(MEM_READ), 32'd0);
      checkOutput("mid_col", 32'(CURSOR_COL), 32'd0);
      checkOutput("mid_row", 32'(CURSOR_ROW), 32'd0);

      repeat (2) @(negedge CLK);
      checkOutput("protocol", 32'(protocol_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
